trng_bit_packer: RTL and testbench
==================================

# trng_bit_packer

Parametrised packer that collects TAKE least-significant bits from each raw TRNG sample and assembles them into OUT_W-bit words. Completed words are presented through a registered valid/ready output stage. The block sits between the entropy sampler (free-running, cannot stall) and the output FIFO/UART path. Words that cannot be delivered are dropped and flagged rather than stalling the source.

## Interface
- DIN_W, 8, width of raw sample bus DIN
- TAKE, 1, LSBs of DIN used per sample; 1 ≤ TAKE ≤ DIN_W
- OUT_W, 8, output word width; must be a multiple of TAKE
- PACK_ENABLE, 1, 1 = pack; 0 = bypass (each sample becomes one word, zero-extended/truncated to OUT_W)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- DIN  in  DIN_W  raw sample
- WE  in  1  DIN valid this cycle; always accepted, no backpressure to source
- FLUSH  in  1  discard partial accumulation
- DOUT  out  OUT_W  packed word
- VALID  out  1  DOUT holds an undelivered word
- READY  in  1  consumer accepts DOUT when VALID & READY
- OVF  out  1  sticky: at least one completed word was dropped since reset
- DROP_CNT  out  16  dropped-word count (see Configuration)

## Operation
- Accumulator: shift register acc (OUT_W−TAKE bits) plus counter cnt, width $clog2(OUT_W/TAKE), range 0..OUT_W/TAKE−1.
- On WE with cnt < last: acc ← {acc, DIN[TAKE-1:0]}; cnt ← cnt+1.
- On WE with cnt = last: word = {acc, DIN[TAKE-1:0]}; cnt ← 0; acc unchanged (don't care). The earliest sample lands in the MSBs.
- Output stage, one entry. Word is loaded if the stage is empty, or if VALID & READY in the same cycle. Otherwise the word is dropped, OVF ← 1 and DROP_CNT increments.
- Handshake: DOUT is stable while VALID=1 and READY=0. VALID falls the cycle after VALID & READY unless a new word loads simultaneously.
- FLUSH: cnt ← 0. The WE sample in the same cycle is discarded. The output stage is untouched.
- Bypass (PACK_ENABLE=0): every WE forms a word directly. Accumulator and FLUSH are inert. Drop rules are identical.
- Priority: RST > FLUSH > WE.

## Timing
- Reset values: DOUT=0, VALID=0, OVF=0, DROP_CNT=0, cnt=0, acc=0.
- Latency: VALID rises the cycle after the WE that completes a word, in both packed and bypass modes.
- Throughput: one word per cycle in bypass when READY is held high. In packed mode, one word per OUT_W/TAKE WE cycles.
- RST mid-word discards the partial word and any pending output word.
- OVF clears only on RST.

## Configuration
- PACK_DROP_CNT_EN defined: DROP_CNT is a 16-bit counter saturating at 16'hFFFF, incremented on each drop.
- Not defined: DROP_CNT is tied to 0 and no counter logic is generated. OVF is present in both cases.

## Structure
- Shared package pack_pkg holds:
  - DROP_CNT_W = 16
  - function pack_cnt_w(OUT_W, TAKE) returning the counter width
  - parameter-legality checks, which raise an elaboration error for OUT_W % TAKE ≠ 0, TAKE > DIN_W, or TAKE = 0
- One sub-module, pack_out_stage: single-entry valid/ready holding register with load/drop decision, OVF and the optional DROP_CNT.

## Test plan
- Defaults, READY=1, DIN LSBs 1,0,1,1,0,0,1,0 on eight consecutive WE → DOUT=8'hB2, VALID high exactly one cycle after the 8th WE.
- TAKE=2, OUT_W=8, DIN[1:0] = 3,0,2,1 with gaps between WE → DOUT=8'hC9; no VALID before the 4th sample.
- READY=0, 16 WE of all-ones LSB → DOUT=8'hFF held with VALID=1, second word dropped, OVF=1, DROP_CNT=1 (0 without PACK_DROP_CNT_EN). Raise READY → VALID drops next cycle.
- Three WE, then FLUSH together with a WE, then eight WE of pattern 8'h3C → single word 8'h3C; first three bits and the FLUSH-cycle bit absent.
- PACK_ENABLE=0, READY=1, DIN=8'h5A then 8'hA5 on consecutive cycles → DOUT=8'h5A then 8'hA5 one cycle later each, no drops.
- RST asserted after 5 WE while a previous word is pending → VALID=0, OVF=0. The next 8 WE produce a fresh, correct word.

Source files
------------

// File: rtl/pack_pkg.sv
// Shared constants and parameter helpers for the TRNG bit packer.
// Legality of DIN_W/TAKE/OUT_W is checked at elaboration via pack_params_ok.
package pack_pkg;

  localparam int DROP_CNT_W = 16;

  // Counter width for OUT_W/TAKE samples per word; at least one bit.
  function automatic int pack_cnt_w(input int out_w, input int take);
    int n;
    if (take <= 0) return 1;
    n = out_w / take;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit pack_params_ok(input int din_w, input int take, input int out_w);
    return (take > 0) && (take <= din_w) && ((out_w % take) == 0);
  endfunction

endpackage

// File: rtl/pack_out_stage.sv
// Single-entry valid/ready holding register; drops a word that cannot load.
// PACK_DROP_CNT_EN adds a saturating drop counter, otherwise DROP_CNT is 0.
module pack_out_stage import pack_pkg::*; #(
  parameter int W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  word_vld,
  input  logic [W-1:0]          word,
  input  logic                  READY,
  output logic [W-1:0]          DOUT,
  output logic                  VALID,
  output logic                  OVF,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  logic load, drop;

  // A full stage frees up in the same cycle it is being consumed.
  assign load = word_vld & (~VALID | READY);
  assign drop = word_vld & ~load;

  always_ff @(posedge CLK) begin
    if (RST) begin
      DOUT  <= '0;
      VALID <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      if (load) begin
        DOUT  <= word;
        VALID <= 1'b1;
      end else if (READY) begin
        VALID <= 1'b0;
      end
      if (drop) OVF <= 1'b1;
    end
  end

`ifdef PACK_DROP_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST)                       DROP_CNT <= '0;
    else if (drop && ~&DROP_CNT)   DROP_CNT <= DROP_CNT + 1'b1;
  end
`else
  assign DROP_CNT = '0;
`endif

endmodule

// File: rtl/trng_bit_packer.sv
// Packs TAKE LSBs per TRNG sample into OUT_W-bit words, earliest sample in MSBs.
// Optional PACK_DROP_CNT_EN enables the dropped-word counter in the output stage.
module trng_bit_packer import pack_pkg::*; #(
  parameter int DIN_W       = 8,
  parameter int TAKE        = 1,
  parameter int OUT_W       = 8,
  parameter int PACK_ENABLE = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DIN_W-1:0]      DIN,
  input  logic                  WE,
  input  logic                  FLUSH,
  output logic [OUT_W-1:0]      DOUT,
  output logic                  VALID,
  input  logic                  READY,
  output logic                  OVF,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  if (!pack_params_ok(DIN_W, TAKE, OUT_W)) begin : g_bad_params
    $error("trng_bit_packer: need 1 <= TAKE <= DIN_W and OUT_W %% TAKE == 0");
  end

  logic             word_vld;
  logic [OUT_W-1:0] word;
  logic             unused_in;

  // Upper DIN bits and FLUSH are legitimately ignored in some configurations.
  assign unused_in = ^{DIN, FLUSH};

  if (PACK_ENABLE == 0) begin : g_bypass
    assign word_vld = WE;
    assign word     = OUT_W'(DIN);
  end else if (OUT_W == TAKE) begin : g_single
    assign word_vld = WE & ~FLUSH;
    assign word     = DIN[TAKE-1:0];
  end else begin : g_pack
    localparam int AW = OUT_W - TAKE;
    localparam int CW = pack_cnt_w(OUT_W, TAKE);
    localparam logic [CW-1:0] LAST = CW'(OUT_W / TAKE - 1);

    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    assign word     = {acc, DIN[TAKE-1:0]};
    assign word_vld = WE & ~FLUSH & (cnt == LAST);

    always_ff @(posedge CLK) begin
      if (RST) begin
        acc <= '0;
        cnt <= '0;
      end else if (FLUSH) begin
        cnt <= '0;
      end else if (WE) begin
        if (cnt == LAST) begin
          cnt <= '0;
        end else begin
          acc <= AW'({acc, DIN[TAKE-1:0]});
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  pack_out_stage #(.W(OUT_W)) u_out (
    .CLK      (CLK),
    .RST      (RST),
    .word_vld (word_vld),
    .word     (word),
    .READY    (READY),
    .DOUT     (DOUT),
    .VALID    (VALID),
    .OVF      (OVF),
    .DROP_CNT (DROP_CNT)
  );

endmodule

// File: tb/tb_trng_bit_packer.sv
// Scoreboard bench: three packer configurations (TAKE=1, TAKE=2, bypass) share stimulus.
// A bit-queue/arithmetic reference model pushes expected words; a negedge monitor pops them.
module tb_trng_bit_packer;

  logic       CLK = 1'b0;
  logic       RST, WE, FLUSH, READY;
  logic [7:0] DIN;

  logic [7:0]  dout  [3];
  logic        valid [3];
  logic        ovf   [3];
  logic [15:0] dcnt  [3];

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  trng_bit_packer #(.DIN_W(8), .TAKE(1), .OUT_W(8), .PACK_ENABLE(1)) dut0 (
    .CLK(CLK), .RST(RST), .DIN(DIN), .WE(WE), .FLUSH(FLUSH), .DOUT(dout[0]),
    .VALID(valid[0]), .READY(READY), .OVF(ovf[0]), .DROP_CNT(dcnt[0]));
  trng_bit_packer #(.DIN_W(8), .TAKE(2), .OUT_W(8), .PACK_ENABLE(1)) dut1 (
    .CLK(CLK), .RST(RST), .DIN(DIN), .WE(WE), .FLUSH(FLUSH), .DOUT(dout[1]),
    .VALID(valid[1]), .READY(READY), .OVF(ovf[1]), .DROP_CNT(dcnt[1]));
  trng_bit_packer #(.DIN_W(8), .TAKE(1), .OUT_W(8), .PACK_ENABLE(0)) dut2 (
    .CLK(CLK), .RST(RST), .DIN(DIN), .WE(WE), .FLUSH(FLUSH), .DOUT(dout[2]),
    .VALID(valid[2]), .READY(READY), .OVF(ovf[2]), .DROP_CNT(dcnt[2]));

  int TK[3] = '{1, 2, 1};
  int PK[3] = '{1, 1, 0};

  // Reference model state: pending bit value/count, stage occupancy, drop stats.
  int         m_acc  [3];
  int         m_n    [3];
  int         m_drop [3];
  bit         m_occ  [3];
  bit         m_ovf  [3];
  logic [7:0] exp_q  [3][$];

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, k, got, exp, $time);
    end
  endtask

  function automatic int exp_dcnt(input int k);
`ifdef PACK_DROP_CNT_EN
    return (m_drop[k] > 65535) ? 65535 : m_drop[k];
`else
    return 0;
`endif
  endfunction

  always @(posedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      bit         have;
      logic [7:0] w;
      have = 1'b0;
      w    = '0;
      if (RST) begin
        m_acc[k] = 0; m_n[k] = 0; m_occ[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
        exp_q[k].delete();
      end else begin
        if (PK[k] == 0) begin
          if (WE) begin have = 1'b1; w = DIN; end
        end else if (FLUSH) begin
          m_acc[k] = 0; m_n[k] = 0;
        end else if (WE) begin
          m_acc[k] = m_acc[k] * (1 << TK[k]) + (int'(DIN) % (1 << TK[k]));
          m_n[k]  += TK[k];
          if (m_n[k] == 8) begin
            have = 1'b1; w = 8'(m_acc[k]); m_acc[k] = 0; m_n[k] = 0;
          end
        end
        if (have) begin
          if (!m_occ[k] || READY) begin
            exp_q[k].push_back(w);
            m_occ[k] = 1'b1;
          end else begin
            m_ovf[k] = 1'b1;
            m_drop[k]++;
          end
        end else if (READY) begin
          m_occ[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      chk("valid", k, 32'(valid[k]), 32'(m_occ[k]));
      chk("ovf", k, 32'(ovf[k]), 32'(m_ovf[k]));
      chk("drop_cnt", k, 32'(dcnt[k]), 32'(exp_dcnt(k)));
      if (valid[k]) begin
        if (exp_q[k].size() == 0) begin
          chk("dout_unexpected", k, 32'(dout[k]), 32'hFFFF_FFFF);
        end else begin
          chk("dout", k, 32'(dout[k]), 32'(exp_q[k][0]));
          if (READY) void'(exp_q[k].pop_front());
        end
      end
    end
  end

  task automatic step(input logic w, input logic [7:0] d, input logic f);
    WE = w; DIN = d; FLUSH = f;
    @(posedge CLK); #1;
    WE = 1'b0; FLUSH = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] b;
    logic [3:0] t2 [4];
    RST = 1'b1; WE = 1'b0; FLUSH = 1'b0; READY = 1'b1; DIN = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dout", 0, 32'(dout[0]), 32'h0);
    chk("rst_valid", 0, 32'(valid[0]), 32'h0);
    chk("rst_ovf", 0, 32'(ovf[0]), 32'h0);
    chk("rst_dcnt", 0, 32'(dcnt[0]), 32'h0);
    RST = 1'b0;

    // Eight single-bit samples form 8'hB2.
    pat = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, {7'b0, pat[7-i]}, 1'b0);
      if (i == 6) chk("b2_early", 0, 32'(valid[0]), 32'h0);
    end
    chk("b2_valid", 0, 32'(valid[0]), 32'h1);
    chk("b2_dout", 0, 32'(dout[0]), 32'hB2);
    step(1'b0, 8'h0, 1'b0);
    chk("b2_valid_fall", 0, 32'(valid[0]), 32'h0);

    // TAKE=2 with gaps: 3,0,2,1 -> 8'hC9.
    step(1'b0, 8'h0, 1'b1);
    t2 = '{4'd3, 4'd0, 4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {4'hA, t2[i]}, 1'b0);
      if (i < 3) begin
        chk("c9_early", 1, 32'(valid[1]), 32'h0);
        step(1'b0, 8'hFF, 1'b0);
      end
    end
    chk("c9_valid", 1, 32'(valid[1]), 32'h1);
    chk("c9_dout", 1, 32'(dout[1]), 32'hC9);

    // Back-pressure: second word dropped while 8'hFF is held.
    step(1'b0, 8'h0, 1'b1);
    READY = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'hFF, 1'b0);
    chk("ff_dout", 0, 32'(dout[0]), 32'hFF);
    chk("ff_valid", 0, 32'(valid[0]), 32'h1);
    chk("ff_ovf", 0, 32'(ovf[0]), 32'h1);
`ifdef PACK_DROP_CNT_EN
    chk("ff_dcnt", 0, 32'(dcnt[0]), 32'h1);
`else
    chk("ff_dcnt", 0, 32'(dcnt[0]), 32'h0);
`endif
    READY = 1'b1;
    step(1'b0, 8'h0, 1'b0);
    chk("ff_release", 0, 32'(valid[0]), 32'h0);

    // FLUSH with a concurrent WE discards partial bits and that sample.
    step(1'b0, 8'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h01, 1'b1);
    pat = 8'h3C;
    for (int i = 0; i < 8; i++) step(1'b1, {7'b0, pat[7-i]}, 1'b0);
    chk("flush_dout", 0, 32'(dout[0]), 32'h3C);
    chk("flush_valid", 0, 32'(valid[0]), 32'h1);

    // Bypass: one word per WE.
    step(1'b1, 8'h5A, 1'b0);
    chk("byp_5a", 2, 32'(dout[2]), 32'h5A);
    step(1'b1, 8'hA5, 1'b0);
    chk("byp_a5", 2, 32'(dout[2]), 32'hA5);
    chk("byp_valid", 2, 32'(valid[2]), 32'h1);

    // Reset mid-word with a pending word, then a fresh word.
    step(1'b0, 8'h0, 1'b1);
    READY = 1'b0;
    for (int i = 0; i < 13; i++) step(1'b1, 8'h01, 1'b0);
    RST = 1'b1;
    step(1'b0, 8'h0, 1'b0);
    RST = 1'b0;
    chk("rst_mid_valid", 0, 32'(valid[0]), 32'h0);
    chk("rst_mid_ovf", 0, 32'(ovf[0]), 32'h0);
    READY = 1'b1;
    b = 8'($urandom);
    for (int i = 0; i < 8; i++) step(1'b1, {7'b0, b[7-i]}, 1'b0);
    chk("rst_fresh_dout", 0, 32'(dout[0]), 32'(b));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      READY = ($urandom_range(0, 2) != 0);
      RST   = ($urandom_range(0, 399) == 0);
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
      RST = 1'b0;
    end
    READY = 1'b1;
    repeat (3) step(1'b0, 8'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
